// File: rtl/acc_seq_pkg.sv
// Shared encodings for the accumulator-CPU sequencer: opcodes, mux selects, ALU ops, FSM states.
package acc_seq_pkg;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_HALTED
  } state_t;

  // Opcodes whose operand comes from data memory need the read issued in DECODE.
  function automatic logic reads_data(input logic [4:0] opc);
    return (opc == OPC_LD) || (opc == OPC_ADD) || (opc == OPC_SUB);
  endfunction

endpackage

// File: rtl/acc_seq_pc.sv
// Program counter: clear to zero, increment with natural wrap, otherwise hold.
module acc_seq_pc #(
  parameter int PC_BITS = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               inc,
  output logic [PC_BITS-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clear) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + PC_BITS'(1);
    end
  end

endmodule

// File: rtl/acc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE controller for the 16-bit accumulator datapath.
// Optional retired-instruction counter (o_retired) enabled by defining ACC_SEQ_RETIRE_CNT_EN.
module acc_sequencer #(
  parameter int PC_BITS  = 11,
  parameter int OPC_BITS = 5,
  parameter int OPR_BITS = 11
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [15:0]         i_instr,
  output logic [PC_BITS-1:0]  o_pc,
  output logic                o_instr_rd,
  output logic [OPR_BITS-1:0] o_data_addr,
  output logic                o_data_rd,
  output logic                o_data_wr,
  output logic [1:0]          o_sel_a,
  output logic                o_sel_b,
  output logic                o_alu_op,
  output logic                o_acc_en,
`ifdef ACC_SEQ_RETIRE_CNT_EN
  output logic [31:0]         o_retired,
`endif
  output logic                o_busy,
  output logic                o_halted
);

  import acc_seq_pkg::*;

  state_t              state;
  state_t              state_next;
  logic [15:0]         ir;
  logic                ir_load;
  logic                pc_clear;
  logic                pc_inc;
  logic [OPC_BITS-1:0] opcode_in;
  logic [OPC_BITS-1:0] opcode_ir;

  assign opcode_in = i_instr[OPR_BITS +: OPC_BITS];
  assign opcode_ir = ir[OPR_BITS +: OPC_BITS];

  acc_seq_pc #(
    .PC_BITS(PC_BITS)
  ) u_pc (
    .clk  (i_clock),
    .rst_n(i_reset),
    .clear(pc_clear),
    .inc  (pc_inc),
    .pc   (o_pc)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (ir_load) begin
        ir <= i_instr;
      end
    end
  end

  always_comb begin
    state_next  = state;
    ir_load     = 1'b0;
    pc_clear    = 1'b0;
    pc_inc      = 1'b0;
    o_instr_rd  = 1'b0;
    o_data_addr = ir[OPR_BITS-1:0];
    o_data_rd   = 1'b0;
    o_data_wr   = 1'b0;
    o_sel_a     = SELA_MEM;
    o_sel_b     = 1'b0;
    o_alu_op    = ALU_ADD;
    o_acc_en    = 1'b0;
    o_busy      = 1'b0;
    o_halted    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          pc_clear   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        o_busy     = 1'b1;
        o_instr_rd = 1'b1;
        state_next = ST_DECODE;
      end
      // IR is not loaded yet, so the memory read address comes straight off the bus.
      ST_DECODE: begin
        o_busy      = 1'b1;
        ir_load     = 1'b1;
        o_data_addr = i_instr[OPR_BITS-1:0];
        o_data_rd   = reads_data(opcode_in);
        state_next  = (opcode_in == OPC_HLT) ? ST_HALTED : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        o_busy     = 1'b1;
        pc_inc     = 1'b1;
        state_next = ST_FETCH;
        case (opcode_ir)
          OPC_STO:  o_data_wr = 1'b1;
          OPC_LD:   begin o_sel_a = SELA_MEM; o_acc_en = 1'b1; end
          OPC_LDI:  begin o_sel_a = SELA_IMM; o_acc_en = 1'b1; end
          OPC_ADD:  begin o_sel_a = SELA_ALU; o_acc_en = 1'b1; end
          OPC_ADDI: begin o_sel_a = SELA_ALU; o_sel_b = 1'b1; o_acc_en = 1'b1; end
          OPC_SUB:  begin o_sel_a = SELA_ALU; o_alu_op = ALU_SUB; o_acc_en = 1'b1; end
          OPC_SUBI: begin o_sel_a = SELA_ALU; o_sel_b = 1'b1; o_alu_op = ALU_SUB; o_acc_en = 1'b1; end
          default:  ;
        endcase
      end
      ST_HALTED: begin
        o_halted = 1'b1;
        if (i_start) begin
          pc_clear   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef ACC_SEQ_RETIRE_CNT_EN
  // pc_clear is asserted exactly when a start is accepted, so it doubles as the counter clear.
  logic [31:0] retired;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      retired <= '0;
    end else if (pc_clear) begin
      retired <= '0;
    end else if (state == ST_EXECUTE && retired != 32'hFFFF_FFFF) begin
      retired <= retired + 32'd1;
    end
  end

  assign o_retired = retired;
`endif

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer (PC_BITS=3) with behavioural program/data memory and accumulator.
module tb_acc_sequencer;

  localparam int PC_BITS = 3;

  // Packed control view: {instr_rd, data_rd, data_wr, sel_a, sel_b, alu_op, acc_en, busy, halted}
  localparam logic [9:0] C_IDLE   = 10'b0000000000;
  localparam logic [9:0] C_FETCH  = 10'b1000000010;
  localparam logic [9:0] C_DEC    = 10'b0000000010;
  localparam logic [9:0] C_DEC_RD = 10'b0100000010;
  localparam logic [9:0] C_X_LDI  = 10'b0000100110;
  localparam logic [9:0] C_X_ADDI = 10'b0001010110;
  localparam logic [9:0] C_X_STO  = 10'b0010000010;
  localparam logic [9:0] C_X_LD   = 10'b0000000110;
  localparam logic [9:0] C_X_SUB  = 10'b0001001110;
  localparam logic [9:0] C_X_NOP  = 10'b0000000010;
  localparam logic [9:0] C_HALT   = 10'b0000000001;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [15:0]        instr;
  logic [PC_BITS-1:0] pc;
  logic               instr_rd;
  logic [10:0]        data_addr;
  logic               data_rd;
  logic               data_wr;
  logic [1:0]         sel_a;
  logic               sel_b;
  logic               alu_op;
  logic               acc_en;
  logic               busy;
  logic               halted;
`ifdef ACC_SEQ_RETIRE_CNT_EN
  logic [31:0]        retired;
`endif

  logic [15:0] imem [8];
  logic [15:0] dmem [2048];
  logic [15:0] dmem_q = '0;
  logic [15:0] acc = '0;
  logic [15:0] imm;
  logic [9:0]  ctl;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  acc_sequencer #(
    .PC_BITS (PC_BITS),
    .OPC_BITS(5),
    .OPR_BITS(11)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_start    (start),
    .i_instr    (instr),
    .o_pc       (pc),
    .o_instr_rd (instr_rd),
    .o_data_addr(data_addr),
    .o_data_rd  (data_rd),
    .o_data_wr  (data_wr),
    .o_sel_a    (sel_a),
    .o_sel_b    (sel_b),
    .o_alu_op   (alu_op),
    .o_acc_en   (acc_en),
`ifdef ACC_SEQ_RETIRE_CNT_EN
    .o_retired  (retired),
`endif
    .o_busy     (busy),
    .o_halted   (halted)
  );

  assign ctl = {instr_rd, data_rd, data_wr, sel_a, sel_b, alu_op, acc_en, busy, halted};
  assign imm = {{5{data_addr[10]}}, data_addr};

  // Synchronous memories: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (instr_rd) instr <= imem[pc];
    if (data_rd)  dmem_q <= dmem[data_addr];
    if (data_wr)  dmem[data_addr] <= acc;
  end

  // Accumulator captures on the falling edge while acc_en is high.
  always @(negedge clk) begin
    if (acc_en) begin
      case (sel_a)
        2'b00:   acc <= dmem_q;
        2'b01:   acc <= imm;
        2'b10:   acc <= alu_op ? acc - (sel_b ? imm : dmem_q) : acc + (sel_b ? imm : dmem_q);
        default: acc <= acc;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [9:0] prog_ctl [12] = '{C_FETCH, C_DEC, C_X_LDI, C_FETCH, C_DEC, C_X_ADDI,
                                C_FETCH, C_DEC, C_X_STO, C_FETCH, C_DEC, C_HALT};
  logic [2:0] prog_pc  [12] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1,
                                3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    instr = '0;
    for (int i = 0; i < 2048; i++) dmem[i] = '0;
    for (int i = 0; i < 8; i++) imem[i] = '0;
    imem[0] = 16'h1805;  // LDI 5
    imem[1] = 16'h2803;  // ADDI 3
    imem[2] = 16'h0810;  // STO 0x010
    imem[3] = 16'h0000;  // HLT

    tick(3);
    checkOutput("reset_ctl", 32'(ctl), 32'(C_IDLE));
    checkOutput("reset_pc", 32'(pc), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Reset asserted while fetching the second instruction.
    applyStimulus();
    tick(3);
    checkOutput("pre_reset_pc", 32'(pc), 32'd1);
    checkOutput("pre_reset_ctl", 32'(ctl), 32'(C_FETCH));
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_ctl", 32'(ctl), 32'(C_IDLE));
    checkOutput("async_reset_pc", 32'(pc), 32'd0);
    checkOutput("async_reset_addr", 32'(data_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    checkOutput("idle_no_strobe", 32'(ctl), 32'(C_IDLE));

    // LDI 5; ADDI 3; STO 0x010; HLT
    applyStimulus();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      checkOutput($sformatf("prog_ctl_c%0d", c + 1), 32'(ctl), 32'(prog_ctl[c]));
      checkOutput($sformatf("prog_pc_c%0d", c + 1), 32'(pc), 32'(prog_pc[c]));
      if (c == 8) checkOutput("sto_addr", 32'(data_addr), 32'h010);
    end
    checkOutput("sto_data", 32'(dmem[16]), 32'd8);
`ifdef ACC_SEQ_RETIRE_CNT_EN
    checkOutput("retired_prog", retired, 32'd3);
`endif

    // LD 0x004; SUB 0x005; HLT
    imem[0] = 16'h1004;
    imem[1] = 16'h3005;
    imem[2] = 16'h0000;
    dmem[4] = 16'h1234;
    dmem[5] = 16'h0034;
    applyStimulus();
`ifdef ACC_SEQ_RETIRE_CNT_EN
    checkOutput("retired_cleared", retired, 32'd0);
`endif
    tick(1);
    checkOutput("ld_decode_ctl", 32'(ctl), 32'(C_DEC_RD));
    checkOutput("ld_decode_addr", 32'(data_addr), 32'h004);
    tick(1);
    checkOutput("ld_exec_ctl", 32'(ctl), 32'(C_X_LD));
    checkOutput("ld_exec_addr", 32'(data_addr), 32'h004);
    tick(1);
    checkOutput("ld_acc", 32'(acc), 32'h1234);
    tick(1);
    checkOutput("sub_decode_ctl", 32'(ctl), 32'(C_DEC_RD));
    checkOutput("sub_decode_addr", 32'(data_addr), 32'h005);
    tick(1);
    checkOutput("sub_exec_ctl", 32'(ctl), 32'(C_X_SUB));
    tick(1);
    checkOutput("sub_acc", 32'(acc), 32'h1200);
    tick(2);
    checkOutput("ld_halt_ctl", 32'(ctl), 32'(C_HALT));
    checkOutput("ld_halt_pc", 32'(pc), 32'd2);

    // Opcode 11111 behaves as a NOP.
    imem[0] = 16'hF800;
    imem[1] = 16'h0000;
    applyStimulus();
    tick(2);
    checkOutput("nop_exec_ctl", 32'(ctl), 32'(C_X_NOP));
    tick(1);
    checkOutput("nop_pc", 32'(pc), 32'd1);
    checkOutput("nop_acc_kept", 32'(acc), 32'h1200);
    tick(2);
    checkOutput("nop_halt_ctl", 32'(ctl), 32'(C_HALT));

    // Start during EXECUTE is ignored; start while HALTED restarts at PC 0.
    imem[0] = 16'h1801;
    imem[1] = 16'h0000;
    applyStimulus();
    tick(2);
    checkOutput("ign_exec_ctl", 32'(ctl), 32'(C_X_LDI));
    applyStimulus();
    checkOutput("ign_fetch_ctl", 32'(ctl), 32'(C_FETCH));
    checkOutput("ign_fetch_pc", 32'(pc), 32'd1);
    checkOutput("ign_acc", 32'(acc), 32'h0001);
    tick(2);
    checkOutput("ign_halt_ctl", 32'(ctl), 32'(C_HALT));
    checkOutput("ign_halt_pc", 32'(pc), 32'd1);
    applyStimulus();
    checkOutput("restart_ctl", 32'(ctl), 32'(C_FETCH));
    checkOutput("restart_pc", 32'(pc), 32'd0);
`ifdef ACC_SEQ_RETIRE_CNT_EN
    checkOutput("restart_retired", retired, 32'd0);
`endif
    tick(5);
    checkOutput("restart_halt_ctl", 32'(ctl), 32'(C_HALT));

    // PC wrap: eight NOPs, then a HLT placed at address 0 after its first fetch.
    for (int i = 0; i < 8; i++) imem[i] = 16'hF800;
    applyStimulus();
    tick(2);
    imem[0] = 16'h0000;
    tick(21);
    checkOutput("wrap_last_ctl", 32'(ctl), 32'(C_X_NOP));
    checkOutput("wrap_last_pc", 32'(pc), 32'd7);
    tick(1);
    checkOutput("wrap_fetch_ctl", 32'(ctl), 32'(C_FETCH));
    checkOutput("wrap_fetch_pc", 32'(pc), 32'd0);
    tick(2);
    checkOutput("wrap_halt_ctl", 32'(ctl), 32'(C_HALT));
    checkOutput("wrap_halt_pc", 32'(pc), 32'd0);
`ifdef ACC_SEQ_RETIRE_CNT_EN
    checkOutput("wrap_retired", retired, 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
Multi-cycle control unit that sequences the 16-bit accumulator datapath of the accumulator CPU.
- Fetches instructions from synchronous program memory, decodes them, and drives the accumulator-input mux selects, the ALU op, the data-memory strobes and the accumulator write enable.
- Sits between program memory, data memory and the accumulator/ALU datapath.
- Owns the program counter.

Parameters:
PC_BITS, 11, program-counter/program-memory address width
OPC_BITS, 5, opcode field width (instruction bits [15:11])
OPR_BITS, 11, operand field width (instruction bits [10:0])

Ports:
i_clock  in  1  system clock; all state updates on rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  single-cycle pulse; starts execution from PC 0 when idle or halted
i_instr  in  16  program-memory read data, valid the cycle after o_instr_rd
o_pc  out  PC_BITS  program-memory address (current PC)
o_instr_rd  out  1  program-memory read strobe
o_data_addr  out  OPR_BITS  data-memory address = latched operand
o_data_rd  out  1  data-memory read strobe
o_data_wr  out  1  data-memory write strobe (stores accumulator)
o_sel_a  out  2  accumulator-input mux: 00 data mem, 01 sign-extended immediate, 10 ALU result
o_sel_b  out  1  ALU operand B: 0 data mem, 1 sign-extended immediate
o_alu_op  out  1  0 add, 1 sub
o_acc_en  out  1  accumulator write enable
o_busy  out  1  high in FETCH/DECODE/EXECUTE
o_halted  out  1  high in HALTED

Behaviour:
- Reset (i_reset low, asynchronous):
  - State goes to IDLE, PC goes to 0, IR goes to 0.
  - Every output strobe goes to 0; o_sel_a=00, o_sel_b=0, o_alu_op=0, o_busy=0, o_halted=0.
- States: IDLE, FETCH, DECODE, EXECUTE, HALTED.
- IDLE: wait for i_start, then PC goes to 0 and state goes to FETCH. i_start in any busy state is ignored.
- FETCH: o_instr_rd=1, o_pc=PC. Next state DECODE.
- DECODE:
  - Latch i_instr into IR.
  - If the opcode is LD, ADD or SUB, assert o_data_rd=1 with o_data_addr from i_instr[10:0]. The data is valid in EXECUTE.
  - HLT goes to HALTED; all other opcodes go to EXECUTE.
- EXECUTE: exactly one cycle, outputs decoded from IR.
  - STO (00001): o_data_wr=1.
  - LD (00010): sel_a=00, acc_en=1.
  - LDI (00011): sel_a=01, acc_en=1.
  - ADD (00100): sel_a=10, sel_b=0, alu_op=0, acc_en=1.
  - ADDI (00101): sel_a=10, sel_b=1, alu_op=0, acc_en=1.
  - SUB (00110): sel_a=10, sel_b=0, alu_op=1, acc_en=1.
  - SUBI (00111): sel_a=10, sel_b=1, alu_op=1, acc_en=1.
  - Opcodes 01000-11111: NOP, no strobes.
  - After the operation, PC goes to PC+1 and state goes to FETCH.
- o_acc_en stays high for the full EXECUTE cycle, so the accumulator's falling-edge capture lands mid-cycle with stable selects.
- o_data_addr holds the IR operand throughout EXECUTE.
- HLT (00000): no datapath strobes; PC holds. HALTED persists until i_start (PC goes to 0, then FETCH) or reset.
- Latency: 3 cycles per instruction; HLT takes 2 cycles to reach HALTED.
- PC width rules:
  - PC increments modulo 2^PC_BITS; 2^PC_BITS-1 wraps to 0.
  - No overflow flag.
- Simultaneous events: reset overrides everything. i_start in the same cycle as the HLT decode is ignored.
- Reset mid-instruction aborts it with no write. A STO in EXECUTE is cut off asynchronously.

Optional Feature:
Macro ACC_SEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output o_retired[31:0], counting instructions completed in EXECUTE (NOPs included, HLT excluded).
  - Cleared by reset and by an accepted i_start; saturates at 32'hFFFF_FFFF.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package acc_seq_pkg holds:
  - opcode localparams (OPC_HLT..OPC_SUBI);
  - o_sel_a encodings (SELA_MEM, SELA_IMM, SELA_ALU);
  - ALU op encodings;
  - state encoding.
- One natural sub-module: acc_seq_pc (PC register with load-zero, increment, hold, wrap).

Test Plan:
1. Reset low mid-FETCH, then release → all outputs 0, o_pc=0, state IDLE; no strobe until i_start.
2. Program LDI 5; ADDI 3; STO 0x010; HLT with i_start → per-instruction acc_en/sel sequence as decoded; o_data_wr at addr 0x010 in cycle 9 after start; o_halted after 11 cycles; PC=3.
3. LD 0x004 (data mem returns 0x1234) → o_data_rd with addr 0x004 in DECODE; EXECUTE sel_a=00, acc_en=1; accumulator holds 0x1234.
4. Opcode 11111 → no acc_en/data_wr; PC advances by 1.
5. PC_BITS=3; 8 NOPs then HLT at address 0 → PC wraps 7→0 and halts there.
6. i_start pulses during EXECUTE and while HALTED → first ignored; second restarts fetch at PC 0 (retire count cleared when the macro is defined).
